// File: rtl/alu_mdu_iter_pkg.sv
// Shared opcodes, multiply/divide sequencer states and op classification
// for the EX-stage ALU with an iterative multiply/divide unit.
package alu_mdu_iter_pkg;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_ADDU  = 5'd1;
  localparam logic [4:0] ALU_SUB   = 5'd2;
  localparam logic [4:0] ALU_SUBU  = 5'd3;
  localparam logic [4:0] ALU_AND   = 5'd4;
  localparam logic [4:0] ALU_OR    = 5'd5;
  localparam logic [4:0] ALU_XOR   = 5'd6;
  localparam logic [4:0] ALU_NOR   = 5'd7;
  localparam logic [4:0] ALU_SLT   = 5'd8;
  localparam logic [4:0] ALU_SLTU  = 5'd9;
  localparam logic [4:0] ALU_LUI   = 5'd10;
  localparam logic [4:0] ALU_SLL   = 5'd11;
  localparam logic [4:0] ALU_SRL   = 5'd12;
  localparam logic [4:0] ALU_SRA   = 5'd13;
  localparam logic [4:0] ALU_MULT  = 5'd16;
  localparam logic [4:0] ALU_MULTU = 5'd17;
  localparam logic [4:0] ALU_DIV   = 5'd18;
  localparam logic [4:0] ALU_DIVU  = 5'd19;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } mdu_state_e;

  function automatic logic is_multicycle(input logic [4:0] op);
    return (op == ALU_MULT) || (op == ALU_MULTU) || (op == ALU_DIV) || (op == ALU_DIVU);
  endfunction

endpackage

// File: rtl/alu_mdu_iter_mdu.sv
// Iterative multiply/divide unit: one shift-add or restoring-divide step per
// clock over unsigned magnitudes, with sign fixup applied in the FIN state.
module alu_mdu_iter_mdu
  import alu_mdu_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             isDiv_i,
  input  logic             isSigned_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             fin_o,
  output logic             divZero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int SHW = $clog2(WIDTH);

  mdu_state_e       state_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q, bMag_q;
  logic             isDiv_q, negLo_q, negHi_q, divZero_q;

  logic             aNeg, bNeg;
  logic [WIDTH-1:0] aMag, bMag;
  logic [WIDTH:0]   addSum, trial;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic [2*WIDTH-1:0] prod, prodFix;

  always_comb begin
    aNeg = isSigned_i & a_i[WIDTH-1];
    bNeg = isSigned_i & b_i[WIDTH-1];
    aMag = aNeg ? -a_i : a_i;
    bMag = bNeg ? -b_i : b_i;
  end

  // hi holds the running partial product / remainder, lo the multiplier / quotient.
  always_comb begin
    addSum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, bMag_q} : '0);
    trial  = {hi_q, lo_q[WIDTH-1]} - {1'b0, bMag_q};
    if (isDiv_q) begin
      if (!trial[WIDTH]) begin
        hi_d = trial[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_d = addSum[WIDTH:1];
      lo_d = {addSum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod    = {hi_q, lo_q};
    prodFix = negLo_q ? -prod : prod;
    hi_o    = hi_q;
    lo_o    = lo_q;
    if (!divZero_q) begin
      if (isDiv_q) begin
        hi_o = negHi_q ? -hi_q : hi_q;
        lo_o = negLo_q ? -lo_q : lo_q;
      end else begin
        hi_o = prodFix[2*WIDTH-1:WIDTH];
        lo_o = prodFix[WIDTH-1:0];
      end
    end
  end

  assign busy_o    = (state_q != S_IDLE);
  assign fin_o     = (state_q == S_FIN);
  assign divZero_o = divZero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      bMag_q    <= '0;
      isDiv_q   <= 1'b0;
      negLo_q   <= 1'b0;
      negHi_q   <= 1'b0;
      divZero_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            isDiv_q <= isDiv_i;
            bMag_q  <= bMag;
            negLo_q <= aNeg ^ bNeg;
            negHi_q <= aNeg;
            cnt_q   <= '0;
            // Divide by zero bypasses the iteration with a fixed answer.
            if (isDiv_i && (b_i == '0)) begin
              divZero_q <= 1'b1;
              hi_q      <= a_i;
              lo_q      <= '1;
              state_q   <= S_FIN;
            end else begin
              divZero_q <= 1'b0;
              hi_q      <= '0;
              lo_q      <= aMag;
              state_q   <= S_RUN;
            end
          end
        end
        S_RUN: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + SHW'(1);
          if (cnt_q == SHW'(WIDTH - 1)) state_q <= S_FIN;
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_mdu_iter.sv
// Registered EX-stage ALU: single-cycle ops complete the clock after start,
// multiply/divide run through the iterative unit and write HI/LO.
module alu_mdu_iter
  import alu_mdu_iter_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [4:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [SHW-1:0]   shamt_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             zero_o,
  output logic             overflow_o,
  output logic             div_zero_o
);

  logic             mduBusy, mduFin, mduDivZero, accept, mduStart;
  logic [WIDTH-1:0] mduHi, mduLo, aluRes;
  logic [WIDTH:0]   addExt, subExt;
  logic             aluOvf;

  logic             done_q, zero_q, overflow_q, divZero_q;
  logic [WIDTH-1:0] result_q, hi_q, lo_q;

  assign accept   = start_i & ~mduBusy;
  assign mduStart = accept & is_multicycle(op_i);

  alu_mdu_iter_mdu #(.WIDTH(WIDTH)) uMdu (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (mduStart),
    .isDiv_i    ((op_i == ALU_DIV) || (op_i == ALU_DIVU)),
    .isSigned_i ((op_i == ALU_MULT) || (op_i == ALU_DIV)),
    .a_i        (a_i),
    .b_i        (b_i),
    .busy_o     (mduBusy),
    .fin_o      (mduFin),
    .divZero_o  (mduDivZero),
    .hi_o       (mduHi),
    .lo_o       (mduLo)
  );

  // Sign-extended by one bit so overflow shows up as disagreeing top bits.
  always_comb begin
    addExt = {a_i[WIDTH-1], a_i} + {b_i[WIDTH-1], b_i};
    subExt = {a_i[WIDTH-1], a_i} - {b_i[WIDTH-1], b_i};
    aluRes = '0;
    aluOvf = 1'b0;
    case (op_i)
      ALU_ADD: begin
        aluRes = addExt[WIDTH-1:0];
        aluOvf = addExt[WIDTH] ^ addExt[WIDTH-1];
      end
      ALU_ADDU: aluRes = addExt[WIDTH-1:0];
      ALU_SUB: begin
        aluRes = subExt[WIDTH-1:0];
        aluOvf = subExt[WIDTH] ^ subExt[WIDTH-1];
      end
      ALU_SUBU: aluRes = subExt[WIDTH-1:0];
      ALU_AND:  aluRes = a_i & b_i;
      ALU_OR:   aluRes = a_i | b_i;
      ALU_XOR:  aluRes = a_i ^ b_i;
      ALU_NOR:  aluRes = ~(a_i | b_i);
      ALU_SLT:  aluRes = {{(WIDTH-1){1'b0}},
                          (a_i[WIDTH-1] != b_i[WIDTH-1]) ? a_i[WIDTH-1] : subExt[WIDTH-1]};
      ALU_SLTU: aluRes = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      ALU_LUI:  aluRes = {b_i[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      ALU_SLL:  aluRes = a_i << shamt_i;
      ALU_SRL:  aluRes = a_i >> shamt_i;
      ALU_SRA:  aluRes = $signed(a_i) >>> shamt_i;
      default: begin
        aluRes = '0;
        aluOvf = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q     <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b1;
      hi_q       <= '0;
      lo_q       <= '0;
      overflow_q <= 1'b0;
      divZero_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (mduFin) begin
        hi_q      <= mduHi;
        lo_q      <= mduLo;
        result_q  <= mduLo;
        zero_q    <= (mduLo == '0);
        divZero_q <= mduDivZero;
        done_q    <= 1'b1;
      end else if (accept) begin
        overflow_q <= 1'b0;
        divZero_q  <= 1'b0;
        if (!is_multicycle(op_i)) begin
          result_q   <= aluRes;
          zero_q     <= (aluRes == '0);
          overflow_q <= aluOvf;
          done_q     <= 1'b1;
        end
      end
    end
  end

  assign busy_o     = mduBusy;
  assign done_o     = done_q;
  assign result_o   = result_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign zero_o     = zero_q;
  assign overflow_o = overflow_q;
  assign div_zero_o = divZero_q;

endmodule

// File: tb/tb_alu_mdu_iter.sv
// Scoreboard bench for alu_mdu_iter (WIDTH=32): directed corner cases plus
// random ops checked against a plain-arithmetic reference model.
module tb_alu_mdu_iter;
  import alu_mdu_iter_pkg::*;

  typedef struct {
    int unsigned cyc;
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        zero;
    logic        ovf;
    logic        dz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [4:0]  op_i = '0;
  logic [31:0] a_i = '0, b_i = '0;
  logic [4:0]  shamt_i = '0;
  logic        busy_o, done_o, zero_o, overflow_o, div_zero_o;
  logic [31:0] result_o, hi_o, lo_o;

  int          checks = 0;
  int          failures = 0;
  int unsigned cycCount = 0;
  int unsigned lastIssue = 0;
  logic [31:0] mHi = '0, mLo = '0;
  exp_t        sbQ[$];

  alu_mdu_iter #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .op_i       (op_i),
    .a_i        (a_i),
    .b_i        (b_i),
    .shamt_i    (shamt_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .zero_o     (zero_o),
    .overflow_o (overflow_o),
    .div_zero_o (div_zero_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycCount <= cycCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycCount);
    end
  endtask

  // Reference model: straight integer arithmetic on 64-bit values.
  function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh, input int unsigned issue,
                                 input logic [31:0] hiIn, input logic [31:0] loIn);
    exp_t e;
    longint sa, sb, s, q, r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    e.cyc = issue + 1;
    e.res = '0;
    e.hi = hiIn;
    e.lo = loIn;
    e.ovf = 1'b0;
    e.dz = 1'b0;
    case (op)
      ALU_ADD: begin
        s = sa + sb;
        e.res = 32'(s);
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      ALU_ADDU: e.res = a + b;
      ALU_SUB: begin
        s = sa - sb;
        e.res = 32'(s);
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      ALU_SUBU: e.res = a - b;
      ALU_AND:  e.res = a & b;
      ALU_OR:   e.res = a | b;
      ALU_XOR:  e.res = a ^ b;
      ALU_NOR:  e.res = ~(a | b);
      ALU_SLT:  e.res = (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLTU: e.res = (a < b) ? 32'd1 : 32'd0;
      ALU_LUI:  e.res = b << 16;
      ALU_SLL:  e.res = a << sh;
      ALU_SRL:  e.res = a >> sh;
      ALU_SRA:  e.res = 32'(sa >>> sh);
      ALU_MULT, ALU_MULTU: begin
        if (op == ALU_MULT) p = 64'(sa * sb);
        else p = {32'd0, a} * {32'd0, b};
        e.hi = p[63:32];
        e.lo = p[31:0];
        e.res = e.lo;
        e.cyc = issue + 34;
      end
      ALU_DIV, ALU_DIVU: begin
        if (b == 32'd0) begin
          e.lo = 32'hFFFF_FFFF;
          e.hi = a;
          e.dz = 1'b1;
          e.cyc = issue + 2;
        end else begin
          if (op == ALU_DIV) begin
            q = sa / sb;
            r = sa % sb;
          end else begin
            q = longint'({32'd0, a}) / longint'({32'd0, b});
            r = longint'({32'd0, a}) % longint'({32'd0, b});
          end
          e.lo = 32'(q);
          e.hi = 32'(r);
          e.cyc = issue + 34;
        end
        e.res = e.lo;
      end
      default: e.res = '0;
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  // Called at a falling edge with the DUT able to accept; holds start for one cycle.
  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] sh);
    exp_t e;
    lastIssue = cycCount;
    e = model(op, a, b, sh, cycCount, mHi, mLo);
    mHi = e.hi;
    mLo = e.lo;
    sbQ.push_back(e);
    start_i = 1'b1;
    op_i = op;
    a_i = a;
    b_i = b;
    shamt_i = sh;
    @(negedge clk);
    start_i = 1'b0;
    op_i = 5'($urandom);
    a_i = $urandom;
    b_i = $urandom;
    shamt_i = 5'($urandom);
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (sbQ.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sbQ.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL done_timeout: got %0d pending expected 0", sbQ.size());
      sbQ.delete();
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_result"}, result_o, 32'd0);
    checkOutput({tag, "_hi"}, hi_o, 32'd0);
    checkOutput({tag, "_lo"}, lo_o, 32'd0);
    checkOutput({tag, "_zero"}, 32'(zero_o), 32'd1);
    checkOutput({tag, "_busy"}, 32'(busy_o), 32'd0);
    checkOutput({tag, "_done"}, 32'(done_o), 32'd0);
    checkOutput({tag, "_ovf"}, 32'(overflow_o), 32'd0);
    checkOutput({tag, "_dz"}, 32'(div_zero_o), 32'd0);
  endtask

  function automatic logic [31:0] pickVal();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done_o) begin
      if (sbQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cycCount);
      end else begin
        e = sbQ.pop_front();
        checkOutput("done_cycle", 32'(cycCount), 32'(e.cyc));
        checkOutput("result", result_o, e.res);
        checkOutput("hi", hi_o, e.hi);
        checkOutput("lo", lo_o, e.lo);
        checkOutput("zero", 32'(zero_o), 32'(e.zero));
        checkOutput("overflow", 32'(overflow_o), 32'(e.ovf));
        checkOutput("div_zero", 32'(div_zero_o), 32'(e.dz));
        checkOutput("busy_at_done", 32'(busy_o), 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [4:0] opList[20];

  initial begin
    int n;
    opList = '{ALU_ADD, ALU_ADDU, ALU_SUB, ALU_SUBU, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
               ALU_SLT, ALU_SLTU, ALU_LUI, ALU_SLL, ALU_SRL, ALU_SRA, ALU_MULT, ALU_MULTU,
               ALU_DIV, ALU_DIVU, 5'd14, 5'd25};
    repeat (3) @(negedge clk);
    #1;
    checkResetState("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkResetState("post_reset");

    applyStimulus(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0);   waitIdle(50);
    applyStimulus(ALU_ADDU, 32'h7FFF_FFFF, 32'd1, 5'd0);  waitIdle(50);
    applyStimulus(ALU_SUB, 32'h8000_0000, 32'd1, 5'd0);   waitIdle(50);
    applyStimulus(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0);   waitIdle(50);
    applyStimulus(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd0);  waitIdle(50);
    applyStimulus(ALU_SRA, 32'h8000_0000, 32'd0, 5'd4);   waitIdle(50);
    applyStimulus(ALU_LUI, 32'd0, 32'h1234_ABCD, 5'd0);   waitIdle(50);
    applyStimulus(5'd30, 32'h1234_5678, 32'h1, 5'd0);     waitIdle(50);

    // MULT with busy window checks and a start that must be ignored.
    applyStimulus(ALU_MULT, 32'hFFFF_FFFE, 32'd3, 5'd0);
    checkOutput("busy_first", 32'(busy_o), 32'd1);
    repeat (4) @(negedge clk);
    start_i = 1'b1; op_i = ALU_ADD; a_i = 32'd5; b_i = 32'd5;
    @(negedge clk);
    start_i = 1'b0;
    n = 0;
    while (cycCount < lastIssue + 33 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("busy_last", 32'(busy_o), 32'd1);
    @(negedge clk);
    checkOutput("done_after_mult", 32'(done_o), 32'd1);
    waitIdle(50);

    applyStimulus(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 5'd0);   waitIdle(100);
    applyStimulus(ALU_DIVU, 32'd7, 32'd0, 5'd0);          waitIdle(100);
    applyStimulus(ALU_ADD, 32'd1, 32'd2, 5'd0);           waitIdle(50);
    applyStimulus(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0); waitIdle(100);

    // Back-to-back: ADD issued in the cycle DIV reports done.
    applyStimulus(ALU_DIV, 32'd100, 32'd7, 5'd0);
    n = 0;
    while (!done_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    applyStimulus(ALU_ADD, 32'd3, 32'd4, 5'd0);
    waitIdle(50);

    // Reset while the multiplier is at step 10.
    applyStimulus(ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    sbQ.delete();
    mHi = '0;
    mLo = '0;
    checkResetState("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checkResetState("after_abort");

    for (int i = 0; i < 150; i++) begin
      applyStimulus(opList[$urandom_range(0, 19)], pickVal(), pickVal(), 5'($urandom));
      waitIdle(100);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
